multiply_issue_ctrl: RTL and testbench

- Control and datapath wrapper directly upstream and downstream of multiply_add_64x64, a 4-stage unsigned macro: o = a*b + c, captured at the sampling edge and visible 3 edges later.
- Accepts multiply-add requests over a valid/ready handshake.
- Converts signed operands to magnitudes, drives the macro and tracks in-flight operations.
- Applies the sign fix-up on the macro output and buffers results in a small FIFO with output backpressure. Used by the execute-stage multiplier.

---
 rtl/multiply_issue_ctrl_pkg.sv | 16 +
 rtl/mul_result_fifo.sv | 44 ++++
 rtl/multiply_add_64x64.sv | 16 +
 rtl/multiply_issue_ctrl.sv | 78 +++++++
 tb/tb_multiply_issue_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/multiply_issue_ctrl_pkg.sv
// multiply_issue_ctrl_pkg: shared constants and record types for the multiply issue controller
package multiply_issue_ctrl_pkg;
  localparam int MAC_LATENCY = 4;
  localparam int PREP_STAGES = 1;
  localparam int MIC_BITS = 64;
  localparam int MIC_TAG_BITS = 4;
  typedef struct packed {
    logic [2*MIC_BITS-1:0] result;
    logic [MIC_TAG_BITS-1:0] tag;
  } res_t;
  typedef struct packed {
    logic valid;
    logic neg;
    logic [MIC_TAG_BITS-1:0] tag;
  } trk_t;
endpackage

// File: rtl/mul_result_fifo.sv
// mul_result_fifo: synchronous FIFO with async reset, flush and a separate occupancy count
module mul_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign valid = count != '0;
  assign do_pop = pop & valid;
  // Head is forced to zero when empty so stale entries never show on the output
  assign head = valid ? mem[rd] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr] <= push_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= nxt(wr);
      if (do_pop) rd <= nxt(rd);
      count <= count + CW'(push) - CW'(do_pop);
    end
endmodule

// File: rtl/multiply_add_64x64.sv
// multiply_add_64x64: 4-stage unsigned o = a*b + c, visible 3 edges after capture
module multiply_add_64x64 (
  input  logic         clk,
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  input  logic [127:0] c,
  output logic [127:0] o
);
  logic [127:0] p1, p2, p3;
  always_ff @(posedge clk) begin
    p1 <= {64'b0, a} * {64'b0, b} + c;
    p2 <= p1;
    p3 <= p2;
    o  <= p3;
  end
endmodule

// File: rtl/multiply_issue_ctrl.sv
// multiply_issue_ctrl: signed/unsigned multiply-add issue, in-flight tracking and result buffering
module multiply_issue_ctrl
  import multiply_issue_ctrl_pkg::*;
#(
  parameter int BITS = MIC_BITS,
  parameter int TAG_BITS = MIC_TAG_BITS,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [BITS-1:0]       req_a,
  input  logic [BITS-1:0]       req_b,
  input  logic [2*BITS-1:0]     req_c,
  input  logic                  req_signed,
  input  logic [TAG_BITS-1:0]   req_tag,
  output logic [BITS-1:0]       mac_a,
  output logic [BITS-1:0]       mac_b,
  output logic [2*BITS-1:0]     mac_c,
  input  logic [2*BITS-1:0]     mac_o,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*BITS-1:0]     out_result,
  output logic [TAG_BITS-1:0]   out_tag
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  trk_t s0;
  trk_t trk [MAC_LATENCY];
  logic [CNT_W-1:0] fifo_cnt;
  logic accept, neg, push;
  int busy;
  res_t wb, head;
  // Credit counts every slot that will eventually need a FIFO entry
  always_comb begin
    busy = int'(fifo_cnt) + int'(s0.valid);
    for (int i = 0; i < MAC_LATENCY; i++) busy = busy + int'(trk[i].valid);
  end
  assign req_ready = !flush && busy < FIFO_DEPTH - PREP_STAGES + 1;
  assign accept = req_valid & req_ready;
  assign neg = req_signed & (req_a[BITS-1] ^ req_b[BITS-1]);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s0 <= '0;
      mac_a <= '0;
      mac_b <= '0;
      mac_c <= '0;
      trk <= '{default: '0};
    end else begin
      s0.valid <= accept;
      if (accept) begin
        s0.neg <= neg;
        s0.tag <= req_tag;
        mac_a <= req_signed && req_a[BITS-1] ? -req_a : req_a;
        mac_b <= req_signed && req_b[BITS-1] ? -req_b : req_b;
        mac_c <= neg ? -req_c : req_c;
      end
      trk[0] <= flush ? '0 : s0;
      for (int i = 1; i < MAC_LATENCY; i++) trk[i] <= flush ? '0 : trk[i-1];
    end
  assign push = trk[MAC_LATENCY-1].valid & !flush;
  assign wb.result = trk[MAC_LATENCY-1].neg ? -mac_o : mac_o;
  assign wb.tag = trk[MAC_LATENCY-1].tag;
  mul_result_fifo #(.WIDTH($bits(res_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .push(push),
    .push_data(wb),
    .pop(out_ready),
    .valid(out_valid),
    .head(head),
    .count(fifo_cnt)
  );
  assign out_result = head.result;
  assign out_tag = head.tag;
endmodule

// File: tb/tb_multiply_issue_ctrl.sv
// tb_multiply_issue_ctrl: randomized and directed checks against a queue-based reference model
module tb_multiply_issue_ctrl;
  logic clk = 0, rst = 1, flush = 0, req_valid = 0, req_signed = 0, out_ready = 1;
  logic [63:0] req_a = 0, req_b = 0, mac_a, mac_b;
  logic [127:0] req_c = 0, mac_c, mac_o, out_result;
  logic [3:0] req_tag = 0, out_tag;
  logic req_ready, out_valid;
  int checks = 0, failures = 0, acc;
  typedef struct {
    logic [127:0] r;
    logic [3:0] t;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  multiply_issue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .req_signed(req_signed), .req_tag(req_tag),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_o(mac_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  multiply_add_64x64 u_mac (.clk(clk), .a(mac_a), .b(mac_b), .c(mac_c), .o(mac_o));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_mac(input logic [63:0] a, input logic [63:0] b,
                                           input logic [127:0] c, input logic s);
    logic [127:0] ax, bx;
    ax = s ? {{64{a[63]}}, a} : {64'b0, a};
    bx = s ? {{64{b[63]}}, b} : {64'b0, b};
    return ax * bx + c;
  endfunction

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 4))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic drive_rand();
    req_a = rand64();
    req_b = rand64();
    req_c = {rand64(), rand64()};
    req_signed = 1'($urandom);
    req_tag = 4'($urandom);
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (flush) exp_q.delete();
      else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("spurious_out", {127'b0, out_valid}, 128'd0);
          else begin
            mon_e = exp_q.pop_front();
            chk("stream_result", out_result, mon_e.r);
            chk("stream_tag", {124'b0, out_tag}, {124'b0, mon_e.t});
          end
        end
        if (req_valid && req_ready)
          exp_q.push_back('{ref_mac(req_a, req_b, req_c, req_signed), req_tag});
      end
    end

  task automatic do_one(input logic [63:0] a, input logic [63:0] b, input logic [127:0] c,
                        input logic s, input logic [3:0] tag, input logic [127:0] exp_r);
    req_a = a; req_b = b; req_c = c; req_signed = s; req_tag = tag; req_valid = 1;
    chk("dir_ready", {127'b0, req_ready}, 128'd1);
    @(posedge clk); #1 req_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k < 5) chk("lat_early", {127'b0, out_valid}, 128'd0);
    end
    chk("lat_valid", {127'b0, out_valid}, 128'd1);
    chk("dir_result", out_result, exp_r);
    chk("dir_tag", {124'b0, out_tag}, {124'b0, tag});
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_out_result", out_result, 128'd0);
    chk("rst_mac_a", {64'b0, mac_a}, 128'd0);
    chk("rst_mac_c", mac_c, 128'd0);
    rst = 0;
    #1 chk("rst_ready", {127'b0, req_ready}, 128'd1);
    @(posedge clk); #1;
    // directed corner operands
    do_one('1, '1, 128'd0, 0, 4'd3, 128'hFFFFFFFFFFFFFFFE_0000000000000001);
    do_one(-64'd3, 64'd5, 128'd7, 1, 4'd5, -128'd8);
    do_one(64'h8000_0000_0000_0000, '1, 128'd0, 1, 4'd9, 128'h0000000000000000_8000000000000000);
    // streaming
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      drive_rand();
      req_valid = 1;
      chk("stream_ready", {127'b0, req_ready}, 128'd1);
      @(posedge clk); #1;
    end
    req_valid = 0;
    repeat (10) @(posedge clk);
    #1 chk("stream_drained", 128'(exp_q.size()), 128'd0);
    // backpressure
    out_ready = 0;
    acc = 0;
    for (int i = 0; i < 24; i++) begin
      drive_rand();
      req_valid = 1;
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    req_valid = 0;
    chk("bp_accepted", 128'(acc), 128'd8);
    chk("bp_full_valid", {127'b0, out_valid}, 128'd1);
    chk("bp_ready_low", {127'b0, req_ready}, 128'd0);
    out_ready = 1;
    repeat (12) @(posedge clk);
    #1 chk("bp_drained", 128'(exp_q.size()), 128'd0);
    chk("bp_empty", {127'b0, out_valid}, 128'd0);
    // flush with 2 buffered and 4 in flight
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      drive_rand();
      req_valid = 1;
      @(posedge clk); #1;
    end
    req_valid = 0;
    @(posedge clk); #1;
    chk("pre_flush_buf", {127'b0, out_valid}, 128'd1);
    flush = 1;
    drive_rand();
    req_valid = 1;
    #1 chk("flush_ready", {127'b0, req_ready}, 128'd0);
    @(posedge clk); #1 flush = 0; req_valid = 0; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("post_flush_idle", {127'b0, out_valid}, 128'd0);
      @(posedge clk); #1;
    end
    do_one(64'd1234, 64'd5678, 128'd9, 0, 4'd7, 128'd7006661);
    repeat (3) begin
      chk("post_flush_only", {127'b0, out_valid}, 128'd0);
      @(posedge clk); #1;
    end
    // async reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      req_valid = 1;
      @(posedge clk); #1;
    end
    req_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1;
    #1 chk("arst_valid", {127'b0, out_valid}, 128'd0);
    chk("arst_result", out_result, 128'd0);
    exp_q.delete();
    @(posedge clk); #1 rst = 0;
    do_one(-64'd7, -64'd6, -128'd2, 1, 4'd12, 128'd40);
    repeat (8) @(posedge clk);
    #1 chk("final_drained", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
